reg_dump_reader: RTL and testbench

Debug read-out engine for the RV32IM FPGA pipeline. On a START request it halts the core and walks the register file through one spare combinational read port, from x0 to x31. Each 32-bit value goes out on a valid/ready stream, which is typically drained by the UART debug bridge. It is the reading counterpart of the writeback path that fills the register file.

---
 rtl/reg_dump_reader.sv | 152 +++++++++++++++
 tb/tb_reg_dump_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: halts the core and streams x0..x(NUM_REGS-1) over valid/ready.
// Optional trailing XOR checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    output logic              HALT_REQ,
    input  logic              HALT_ACK,
    output logic [ADDR_W-1:0] RF_ADDR,
    input  logic [DATA_W-1:0] RF_DATA,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic [ADDR_W-1:0] DUMP_INDEX,
    output logic              DUMP_LAST,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {
        StIdle,
        StHaltWait,
        StRead,
        StSend,
        StFinish
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              halt_req_q, halt_req_d;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              csum_q, csum_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        acc_d   = acc_q;
        csum_d  = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    idx_d   = '0;
                    state_d = StHaltWait;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = '0;
                    csum_d  = 1'b0;
`endif
                end
            end
            StHaltWait: begin
                if (HALT_ACK) state_d = StRead;
            end
            StRead: begin
                // A dropped ACK stalls the read so nothing is captured from an unfrozen file.
                if (HALT_ACK) begin
                    data_d  = RF_DATA;
                    index_d = idx_q;
                    state_d = StSend;
`ifdef REG_DUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ RF_DATA;
                    last_d  = 1'b0;
`else
                    last_d  = (idx_q == LastIdx);
`endif
                end
            end
            StSend: begin
                if (DUMP_READY) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (csum_q) begin
                        state_d = StFinish;
                    end else if (idx_q == LastIdx) begin
                        // Stay in SEND and present the checksum as one extra beat.
                        data_d  = acc_q;
                        index_d = '0;
                        last_d  = 1'b1;
                        csum_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StRead;
                    end
`else
                    if (idx_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StRead;
                    end
`endif
                end
            end
            StFinish: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        halt_req_d = (state_d == StHaltWait) || (state_d == StRead) || (state_d == StSend);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            index_q    <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            halt_req_q <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q      <= '0;
            csum_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            index_q    <= index_d;
            data_q     <= data_d;
            last_q     <= last_d;
            halt_req_q <= halt_req_d;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_q      <= acc_d;
            csum_q     <= csum_d;
`endif
        end
    end

    assign HALT_REQ   = halt_req_q;
    assign RF_ADDR    = idx_q;
    assign DUMP_VALID = (state_q == StSend);
    assign DUMP_DATA  = data_q;
    assign DUMP_INDEX = index_q;
    assign DUMP_LAST  = last_q;
    assign BUSY       = (state_q != StIdle);
    assign DONE       = (state_q == StFinish);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: a beat-queue model of the dump plus per-cycle
// protocol checks, with literal expectations for latency and payloads.
module tb_reg_dump_reader;

    localparam int NR = 32;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int NBEATS = NR + EXTRA;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  index;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt_ack = 1'b0;
    logic        dump_ready = 1'b0;
    logic        halt_req, dump_valid, dump_last, busy, done;
    logic [4:0]  rf_addr, dump_index;
    logic [31:0] rf_data, dump_data;
    logic [31:0] rf_mem [NR];

    assign rf_data = rf_mem[rf_addr];

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .HALT_REQ  (halt_req),
        .HALT_ACK  (halt_ack),
        .RF_ADDR   (rf_addr),
        .RF_DATA   (rf_data),
        .DUMP_VALID(dump_valid),
        .DUMP_READY(dump_ready),
        .DUMP_DATA (dump_data),
        .DUMP_INDEX(dump_index),
        .DUMP_LAST (dump_last),
        .BUSY      (busy),
        .DONE      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_pass = 0;
    int          n_total = 0;
    beat_t       exp_q[$];
    int          beats, stall7, stall_n;
    int          rdy_mode, ack_mode;
    int unsigned start_cyc;
    logic [31:0] last_data, data7;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [4:0]  prev_index;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    task automatic monitor_step();
        beat_t e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("busy_eq_halt_or_done", 64'(busy), 64'(halt_req | done));
            if (!busy) chk("rf_addr_idle", 64'(rf_addr), 64'd0);
            if (dump_valid) chk("halt_while_valid", 64'(halt_req), 64'd1);
            if (done) chk("done_all_beats", 64'(exp_q.size()), 64'd0);
            if (prev_stall) begin
                chk("stall_valid", 64'(dump_valid), 64'd1);
                chk("stall_data", 64'(dump_data), 64'(prev_data));
                chk("stall_index", 64'(dump_index), 64'(prev_index));
                chk("stall_last", 64'(dump_last), 64'(prev_last));
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_beat");
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(dump_data), 64'(e.data));
                    chk("beat_index", 64'(dump_index), 64'(e.index));
                    chk("beat_last", 64'(dump_last), 64'(e.last));
                end
                beats++;
                last_data = dump_data;
                if (dump_index == 5'd7 && !dump_last) data7 = dump_data;
                prev_stall = 1'b0;
            end else if (dump_valid) begin
                prev_stall = 1'b1;
                prev_data  = dump_data;
                prev_index = dump_index;
                prev_last  = dump_last;
                if (dump_index == 5'd7) stall7++;
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    task automatic build_exp();
        logic [31:0] acc;
        acc = '0;
        exp_q.delete();
        for (int k = 0; k < NR; k++) begin
            exp_q.push_back('{data: rf_mem[k], index: 5'(k),
                              last: 1'((EXTRA == 0) && (k == NR - 1))});
            acc ^= rf_mem[k];
        end
        if (EXTRA != 0) exp_q.push_back('{data: acc, index: 5'd0, last: 1'b1});
        beats = 0;
        stall7 = 0;
        stall_n = 0;
    endtask

    task automatic drive_inputs();
        case (rdy_mode)
            1: dump_ready = 1'($urandom_range(0, 1));
            2: begin
                if (dump_valid && dump_index == 5'd7 && stall_n < 5) begin
                    dump_ready = 1'b0;
                    stall_n++;
                end else begin
                    dump_ready = 1'b1;
                end
            end
            default: dump_ready = 1'b1;
        endcase
        if (ack_mode == 1) halt_ack = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        drive_inputs();
        @(posedge clk); #1;
        start = 1'b0;
        drive_inputs();
    endtask

    task automatic wait_valid(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dump_valid) seen = 1;
            else begin @(posedge clk); #1; drive_inputs(); end
        end
        if (!seen) fail_now("valid_timeout");
    endtask

    task automatic wait_done(input int budget, output int lat);
        bit seen;
        seen = 0;
        lat = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat = int'(cyc - start_cyc);
            end else begin
                @(posedge clk); #1; drive_inputs();
            end
        end
        if (!seen) begin
            fail_now("done_timeout");
        end else begin
            @(posedge clk); #1; drive_inputs();
            @(negedge clk);
            chk("after_done_busy", 64'(busy), 64'd0);
            chk("after_done_halt", 64'(halt_req), 64'd0);
        end
    endtask

    initial begin
        int  lat;
        int unsigned ack_cyc;
        bit  found;
        rdy_mode = 0;
        ack_mode = 0;
        prev_stall = 1'b0;
        for (int k = 0; k < NR; k++) rf_mem[k] = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs_zero", {halt_req, rf_addr, dump_valid, dump_data, dump_index,
                                      dump_last, busy, done}, 64'd0);
        end

        // Basic dump
        for (int k = 0; k < NR; k++) rf_mem[k] = 32'h1000_0000 + 32'(k);
        halt_ack = 1'b1;
        build_exp();
        pulse_start();
        wait_valid(20);
        chk("first_valid_latency", 64'(cyc - start_cyc), 64'd3);
        chk("first_beat_data", 64'(dump_data), 64'h1000_0000);
        @(posedge clk); #1; drive_inputs();
        wait_done(200, lat);
        chk("basic_done_latency", 64'(lat), 64'(66 + EXTRA));
        chk("basic_beats", 64'(beats), 64'(NBEATS));
`ifndef REG_DUMP_CHECKSUM_EN
        chk("basic_last_data", 64'(last_data), 64'h1000_001F);
`endif

        // Backpressure on x7
        rf_mem[7] = 32'hDEAD_BEEF;
        rdy_mode = 2;
        build_exp();
        pulse_start();
        wait_done(300, lat);
        chk("bp_stall_len", 64'(stall7), 64'd5);
        chk("bp_x7_data", 64'(data7), 64'hDEAD_BEEF);
        chk("bp_beats", 64'(beats), 64'(NBEATS));
        chk("bp_done_latency", 64'(lat), 64'(71 + EXTRA));
        rdy_mode = 0;

        // Halt handshake
        halt_ack = 1'b0;
        build_exp();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("halt_wait_state", {halt_req, dump_valid}, 64'b10);
            @(posedge clk); #1; drive_inputs();
        end
        halt_ack = 1'b1;
        ack_cyc = cyc;
        wait_valid(20);
        chk("ack_to_valid", 64'(cyc - ack_cyc), 64'd2);
        @(posedge clk); #1; drive_inputs();
        wait_done(200, lat);
        chk("halt_beats", 64'(beats), 64'(NBEATS));

        // Reset mid-dump during the SEND of index 12
        build_exp();
        pulse_start();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (dump_valid && dump_index == 5'd12) found = 1;
        end
        if (!found) fail_now("idx12_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midreset_outputs_zero", {halt_req, rf_addr, dump_valid, dump_data, dump_index,
                                      dump_last, busy, done}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        build_exp();
        pulse_start();
        wait_valid(20);
        chk("restart_index", 64'(dump_index), 64'd0);
        @(posedge clk); #1; drive_inputs();
        wait_done(200, lat);
        chk("restart_beats", 64'(beats), 64'(NBEATS));

`ifdef REG_DUMP_CHECKSUM_EN
        // Checksum payload
        for (int k = 0; k < NR; k++) rf_mem[k] = '0;
        rf_mem[1] = 32'h0000_00FF;
        rf_mem[2] = 32'h0000_0F0F;
        build_exp();
        pulse_start();
        wait_done(200, lat);
        chk("csum_beats", 64'(beats), 64'd33);
        chk("csum_value", 64'(last_data), 64'h0000_0FF0);
`endif

        // Randomized contents, backpressure and halt acknowledge
        rdy_mode = 1;
        ack_mode = 1;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NR; k++) rf_mem[k] = $urandom;
            build_exp();
            pulse_start();
            wait_done(3000, lat);
            chk("rand_beats", 64'(beats), 64'(NBEATS));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
